// File: rtl/if_fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Word width, reset PC, NOP encoding, FSM state codes, IF/ID bundle.
package if_fetch_stage_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_D = 32'h0000_3000;
  localparam logic [XLEN-1:0] NOP_D      = 32'h0000_0000;

  localparam logic [2:0] ST_REQ  = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd1;
  localparam logic [2:0] ST_FULL = 3'd2;
  localparam logic [2:0] ST_DROP = 3'd3;
  localparam logic [2:0] ST_ERR  = 3'd4;

  typedef enum logic [2:0] {
    S_REQ  = ST_REQ,
    S_WAIT = ST_WAIT,
    S_FULL = ST_FULL,
    S_DROP = ST_DROP,
    S_ERR  = ST_ERR
  } fetch_st_e;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic            adel;
  } if_id_t;

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory bus: req/addr out, ready/rvalid/rdata back.
// master = fetch stage, slave = instruction memory.
interface if_fetch_stage_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/if_fetch_stage_if_id_reg.sv
// IF/ID pipeline register: i_flush > i_load > hold-on-stall > bubble.
// Ports: clk, rst_n, i_flush, i_stall, i_load, i_data -> o_valid, o_data.
module if_fetch_stage_if_id_reg
  import if_fetch_stage_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   i_flush,
  input  logic   i_stall,
  input  logic   i_load,
  input  if_id_t i_data,
  output logic   o_valid,
  output if_id_t o_data
);

  logic   r_valid;
  if_id_t r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (!i_stall) begin
      // entry consumed by ID, nothing new to hand over
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/if_fetch_stage.sv
// Fetch stage: PC, single-outstanding imem access, skid, IF/ID register.
// Ports: clk, rst_n, stall, flush, redirect_*, imem (master), pc, id_*.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_D,
  parameter logic [31:0] NOP_INST = NOP_D
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               flush,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  if_fetch_stage_if.master   imem,
  output logic [31:0]        pc,
  output logic               id_valid,
  output logic [31:0]        id_inst,
  output logic [31:0]        id_pc,
  output logic [31:0]        id_pc4,
  output logic               id_adel
);

  fetch_st_e   r_state;
  logic [31:0] r_pc;
  logic [31:0] r_req_pc;
  logic [31:0] r_skid;

  fetch_st_e   w_state_nx;
  logic [31:0] w_pc_nx;
  logic        w_aligned;
  logic        w_hs;
  logic        w_acc;
  logic        w_kill;
  logic        w_load;
  logic        w_skid_we;
  logic        w_req_pc_we;
  logic        w_valid;
  if_id_t      w_ld;
  if_id_t      w_q;

  assign w_aligned = (r_pc[1:0] == 2'b00);
  assign w_kill    = flush | redirect_valid;
  assign w_acc     = ~stall | ~w_valid;

  // gated by rst_n so the bus is quiet while reset is held
  assign imem.imem_req  = rst_n & (r_state == S_REQ) & w_aligned;
  assign imem.imem_addr = r_pc;
  assign w_hs = imem.imem_req & imem.imem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_REQ;
      r_pc     <= RESET_PC;
      r_req_pc <= '0;
      r_skid   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_pc    <= w_pc_nx;
      if (w_req_pc_we) r_req_pc <= r_pc;
      if (w_skid_we)   r_skid   <= imem.imem_rdata;
    end
  end

  always_comb begin
    w_state_nx  = r_state;
    w_pc_nx     = r_pc;
    w_load      = 1'b0;
    w_skid_we   = 1'b0;
    w_req_pc_we = 1'b0;
    w_ld        = '0;

    unique case (r_state)
      S_REQ: begin
        if (!w_aligned) begin
          if (!w_kill && w_acc) begin
            w_load      = 1'b1;
            w_ld.inst   = NOP_INST;
            w_ld.pc     = r_pc;
            w_ld.pc4    = r_pc + 32'd4;
            w_ld.adel   = 1'b1;
            w_state_nx  = S_ERR;
          end
        end else if (w_hs) begin
          w_req_pc_we = 1'b1;
          w_pc_nx     = r_pc + 32'd4;
          w_state_nx  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem.imem_rvalid) begin
          if (w_kill) begin
            w_state_nx = S_REQ;
          end else if (w_acc) begin
            w_load     = 1'b1;
            w_ld.inst  = imem.imem_rdata;
            w_ld.pc    = r_req_pc;
            w_ld.pc4   = r_req_pc + 32'd4;
            w_state_nx = S_REQ;
          end else begin
            w_skid_we  = 1'b1;
            w_state_nx = S_FULL;
          end
        end
      end
      S_FULL: begin
        // skid PC is r_req_pc: no new request is accepted while FULL
        if (w_kill) begin
          w_state_nx = S_REQ;
        end else if (w_acc) begin
          w_load     = 1'b1;
          w_ld.inst  = r_skid;
          w_ld.pc    = r_req_pc;
          w_ld.pc4   = r_req_pc + 32'd4;
          w_state_nx = S_REQ;
        end
      end
      S_DROP: begin
        if (imem.imem_rvalid) w_state_nx = S_REQ;
      end
      S_ERR: begin
        w_state_nx = S_ERR;
      end
      default: begin
        w_state_nx = S_REQ;
      end
    endcase

    // redirect overrides everything; a response still owed goes to DROP
    if (redirect_valid) begin
      w_pc_nx = redirect_pc;
      if ((r_state == S_REQ) && w_hs)
        w_state_nx = S_DROP;
      else if ((r_state == S_WAIT || r_state == S_DROP) &&
               !imem.imem_rvalid)
        w_state_nx = S_DROP;
      else
        w_state_nx = S_REQ;
    end
  end

  if_fetch_stage_if_id_reg u_if_id (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (w_kill),
    .i_stall (stall),
    .i_load  (w_load),
    .i_data  (w_ld),
    .o_valid (w_valid),
    .o_data  (w_q)
  );

  assign pc       = r_pc;
  assign id_valid = w_valid;
  assign id_inst  = w_q.inst;
  assign id_pc    = w_q.pc;
  assign id_pc4   = w_q.pc4;
  assign id_adel  = w_q.adel;

endmodule
